// File: rtl/fpm_pkg.sv
// Shared constants, state encoding and packed-word layout for the half-format multiplier datapath.
package fpm_pkg;

    localparam int unsigned EXP_W  = 6;
    localparam int unsigned MAN_W  = 10;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = EXP_W + MAN_W;

    localparam logic [EXP_W-1:0] BIAS    = 6'd31;
    localparam logic [EXP_W-1:0] EXP_MIN = {1'b1, {(EXP_W-1){1'b0}}};

    // Packed word is {exp, man} with the mantissa in the low bits.
    localparam int unsigned MAN_LSB = 0;
    localparam int unsigned EXP_LSB = MAN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fpm_state_e;

endpackage

// File: rtl/fpm_post_normalizer.sv
// Iterative one-bit-per-cycle post-normalizer for the multiplier product, valid/ready on both sides.
// Optional FLUSH_UNDERFLOW_EN: flush to zero instead of wrapping the exponent below -32.
module fpm_post_normalizer
    import fpm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [MAN_W-1:0]   in_man,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic [CNT_W-1:0]   out_shift,
    output logic               out_uflow
);

    fpm_state_e          state_q, state_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MAN_W-1:0]    man_q, man_d, man_sh;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                uflow_q, uflow_d;
    logic                in_ready_d;
    logic                out_valid_d;
    logic [WORD_W-1:0]   out_data_d;
    logic [CNT_W-1:0]    out_shift_d;
    logic                out_uflow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            man_q     <= '0;
            cnt_q     <= '0;
            uflow_q   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
            out_uflow <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            man_q     <= man_d;
            cnt_q     <= cnt_d;
            uflow_q   <= uflow_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_shift <= out_shift_d;
            out_uflow <= out_uflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        man_d       = man_q;
        cnt_d       = cnt_q;
        uflow_d     = uflow_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_shift_d = out_shift;
        out_uflow_d = out_uflow;
        man_sh      = man_q << 1;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d   = in_exp;
                    man_d   = in_man;
                    cnt_d   = '0;
                    uflow_d = 1'b0;
                    if (in_man == '0) begin
                        // Zero product packs as an all-zero word.
                        exp_d   = '0;
                        state_d = DONE;
                    end else if (in_man[MAN_W-1]) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
`ifdef FLUSH_UNDERFLOW_EN
                        if (in_exp == EXP_MIN) begin
                            exp_d   = '0;
                            man_d   = '0;
                            uflow_d = 1'b1;
                            state_d = DONE;
                        end
`endif
                    end
                end
            end
            SHIFT: begin
                man_d = man_sh;
                exp_d = exp_q - EXP_W'(1);
                cnt_d = cnt_q + CNT_W'(1);
                if (man_sh[MAN_W-1]) begin
                    state_d = DONE;
                end
`ifdef FLUSH_UNDERFLOW_EN
                if (exp_q == EXP_MIN) begin
                    exp_d   = '0;
                    man_d   = '0;
                    cnt_d   = cnt_q;
                    uflow_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                // First DONE cycle loads the output registers; they then hold until accepted.
                if (!out_valid) begin
                    out_valid_d                        = 1'b1;
                    out_data_d[EXP_LSB +: EXP_W]       = exp_q;
                    out_data_d[MAN_LSB +: MAN_W]       = man_q;
                    out_shift_d                        = cnt_q;
                    out_uflow_d                        = uflow_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_fpm_post_normalizer.sv
// Directed table-driven bench for fpm_post_normalizer, plus stall and mid-shift reset sequences.
module tb_fpm_post_normalizer;
    import fpm_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [EXP_W-1:0]   in_exp;
    logic [MAN_W-1:0]   in_man;
    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_data;
    logic [CNT_W-1:0]   out_shift;
    logic               out_uflow;

    int checks   = 0;
    int failures = 0;

    fpm_post_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_uflow (out_uflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [5:0]      exp_in;
        logic [9:0]      man_in;
        logic [15:0]     data;
        logic [3:0]      shift;
        logic            uflow;
        int              lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Present one operand; returns once it has been captured (edge N).
    task automatic apply(input logic [5:0] e, input logic [9:0] m);
        int guard = 0;
        @(negedge clk);
        in_exp   = e;
        in_man   = m;
        in_valid = 1'b1;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after the capture edge; counts edges to out_valid.
    task automatic expect_result(input string name, input logic [15:0] data,
                                 input logic [3:0] shift, input logic uflow, input int lat);
        int n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        // The negedge after capture is before the first post-capture edge, so n counts edges.
        chk({name, "_lat"},   32'(n - 1 + 1), 32'(lat + 1));
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"},  32'(out_data),  32'(data));
        chk({name, "_shift"}, 32'(out_shift), 32'(shift));
        chk({name, "_uflow"}, 32'(out_uflow), 32'(uflow));
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_drop"},  32'(out_valid), 32'd0);
        chk({name, "_ready"}, 32'(in_ready),  32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"norm",    6'h05, 10'h200, 16'h1600, 4'd0, 1'b0, 1});
        vecs.push_back('{"lz9",     6'h05, 10'h001, 16'hF200, 4'd9, 1'b0, 10});
        vecs.push_back('{"zero",    6'h12, 10'h000, 16'h0000, 4'd0, 1'b0, 1});
        vecs.push_back('{"allone",  6'h00, 10'h3FF, 16'h03FF, 4'd0, 1'b0, 1});
        vecs.push_back('{"lz2",     6'h0A, 10'h080, 16'h2200, 4'd2, 1'b0, 3});
        vecs.push_back('{"lz1wrap", 6'h3F, 10'h155, 16'hFAAA, 4'd1, 1'b0, 2});
`ifdef FLUSH_UNDERFLOW_EN
        vecs.push_back('{"uflow",   6'h21, 10'h004, 16'h0000, 4'd1, 1'b1, 3});
        vecs.push_back('{"uflow0",  6'h20, 10'h100, 16'h0000, 4'd0, 1'b1, 1});
`else
        vecs.push_back('{"wrap7",   6'h21, 10'h004, 16'h6A00, 4'd7, 1'b0, 8});
        vecs.push_back('{"wrap1",   6'h20, 10'h100, 16'h7E00, 4'd1, 1'b0, 2});
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_exp = '0; in_man = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_shift", 32'(out_shift), 32'd0);
        chk("rst_uflow", 32'(out_uflow), 32'd0);

        foreach (vecs[i]) begin
            apply(vecs[i].exp_in, vecs[i].man_in);
            expect_result(vecs[i].name, vecs[i].data, vecs[i].shift, vecs[i].uflow, vecs[i].lat);
            release_result(vecs[i].name);
        end

        // Stall: result held with out_ready low while a new operand is offered.
        apply(6'h05, 10'h200);
        expect_result("stall", 16'h1600, 4'd0, 1'b0, 1);
        in_exp = 6'h0A; in_man = 10'h080; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data",  32'(out_data),  32'h1600);
            chk("stall_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        expect_result("stall_next", 16'h2200, 4'd2, 1'b0, 3);
        release_result("stall_next");

        // Reset while shifting discards the pending result.
        apply(6'h05, 10'h001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_ready", 32'(in_ready),  32'd1);
        chk("rstmid_data",  32'(out_data),  32'd0);
        chk("rstmid_shift", 32'(out_shift), 32'd0);
        apply(6'h05, 10'h001);
        expect_result("post_rst", 16'hF200, 4'd9, 1'b0, 10);
        release_result("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
